// File: rtl/sub_ctrl_pkg.sv
// sub_ctrl_pkg
//   Shared definitions for the subtractor arbitration controller:
//   FSM state encoding, requester ids, result width and a zero-detect
//   helper used when the result is captured.
package sub_ctrl_pkg;

  // Width of the shared Subtractor datapath; the controller only supports this.
  localparam int SUB_W = 8;
  // Result width: difference plus borrow in the MSB.
  localparam int RES_W = SUB_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  // Zero flag looks only at the difference bits, never at the borrow.
  function automatic logic is_zero(input logic [SUB_W-1:0] i_val);
    return (i_val == '0);
  endfunction

endpackage

// File: rtl/Subtractor.sv
// Subtractor
//   8-bit unsigned subtractor shared by the arbitration controller.
//   Ports:
//     A - minuend
//     B - subtrahend
//     D - 9-bit two's-complement difference; D[8] is the borrow out of
//         the MSB stage (set when A < B unsigned)
module Subtractor (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [8:0] D
);

  // Zero-extending both operands makes bit 8 of the difference the borrow.
  assign D = {1'b0, A} - {1'b0, B};

endmodule

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2
//   Two-way round-robin arbiter. The grant is combinational; a registered
//   preference bit remembers who should win the next tie.
//   Ports:
//     clk, rst       - clock and asynchronous active-high reset
//     i_en           - grants may be issued this cycle
//     i_req0/i_req1  - requests
//     o_gnt0/o_gnt1  - one-hot grant (both 0 when disabled or no request)
module rr_arbiter_2 (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  // 0: req0 wins a tie, 1: req1 wins a tie.
  logic r_prefer1;

  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_en) begin
      if (i_req0 && i_req1) begin
        o_gnt0 = !r_prefer1;
        o_gnt1 = r_prefer1;
      end else begin
        o_gnt0 = i_req0;
        o_gnt1 = i_req1;
      end
    end
  end

  // Preference moves only on a real grant, to the requester that lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prefer1 <= 1'b0;
    end else if (o_gnt0) begin
      r_prefer1 <= 1'b1;
    end else if (o_gnt1) begin
      r_prefer1 <= 1'b0;
    end
  end

endmodule

// File: rtl/sub_arbiter_ctrl.sv
// sub_arbiter_ctrl
//   Shares one Subtractor between two valid/ready requesters with
//   round-robin arbitration, holds the winner's operands for EXEC_CYCLES
//   cycles, then presents the registered 9-bit result (borrow in the MSB)
//   with owner id and zero flag, driving EN to the downstream tri-state
//   stage while the result is presented.
//
//   state | meaning
//   IDLE  | waiting for a request; grant issued combinationally
//   EXEC  | latched operands on the Subtractor, counting down
//   DONE  | result presented (res_valid/EN) until res_ready
//
//   Ports:
//     clk, rst                       - clock, async active-high reset
//     reqN_valid/reqN_a/reqN_b       - requester N operation (N = 0, 1)
//     reqN_ready                     - requester N accepted this cycle
//     res_valid/res_ready            - result handshake
//     res_data                       - a-b, bit WIDTH is borrow
//     res_id                         - requester owning res_data
//     res_zero                       - difference bits are all zero
//     EN                             - downstream tri-state enable
//     busy                           - controller not in IDLE
module sub_arbiter_ctrl
  import sub_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_data,
  output logic             res_id,
  output logic             res_zero,
  output logic             EN,
  output logic             busy
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_owner;
  logic [RES_W-1:0]   r_res_data;
  logic               r_res_id;
  logic               r_res_zero;

  logic               w_arb_en;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_accept;
  logic               w_capture;
  logic [RES_W-1:0]   w_diff;

  // Reset is folded into the enable so the readys read 0 while rst is high.
  assign w_arb_en = (r_state == IDLE) && !rst;

  rr_arbiter_2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_arb_en),
    .i_req0 (req0_valid),
    .i_req1 (req1_valid),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );

  Subtractor u_sub (
    .A (r_a),
    .B (r_b),
    .D (w_diff)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt0 || w_gnt1) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_owner    <= ID_REQ0;
      r_res_data <= '0;
      r_res_id   <= ID_REQ0;
      r_res_zero <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_a     <= w_gnt1 ? req1_a : req0_a;
        r_b     <= w_gnt1 ? req1_b : req0_b;
        r_owner <= w_gnt1 ? ID_REQ1 : ID_REQ0;
      end
      if (w_capture) begin
        r_res_data <= w_diff;
        r_res_zero <= is_zero(w_diff[WIDTH-1:0]);
        r_res_id   <= r_owner;
      end
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign res_valid  = (r_state == DONE);
  assign EN         = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign res_data   = r_res_data;
  assign res_id     = r_res_id;
  assign res_zero   = r_res_zero;

endmodule

// File: doc/sub_arbiter_ctrl.md
Name: sub_arbiter_ctrl

Overview:
Controller that shares one 8-bit Subtractor datapath between two requesters using valid/ready handshakes and round-robin arbitration. It latches the winner's operands and sequences the subtraction over a configurable number of execute cycles. It registers the 9-bit result with borrow and zero flags and drives EN of the downstream Three_State_Arithmetic stage while a result is presented. It sits between the ULA operand sources and the tri-state result bus.

Parameters:
WIDTH, 8, operand width; only 8 is legal, matching the shared Subtractor
EXEC_CYCLES, 1, cycles operands are held stable on the Subtractor before the result is captured; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_a  input  WIDTH  requester 0 minuend
req0_b  input  WIDTH  requester 0 subtrahend
req0_ready  output  1  requester 0 accepted this cycle
req1_valid  input  1  requester 1 has an operation
req1_a  input  WIDTH  requester 1 minuend
req1_b  input  WIDTH  requester 1 subtrahend
req1_ready  output  1  requester 1 accepted this cycle
res_valid  output  1  result available
res_ready  input  1  consumer takes the result
res_data  output  WIDTH+1  a-b; bit WIDTH is borrow
res_id  output  1  requester that owns res_data
res_zero  output  1  res_data[WIDTH-1:0] == 0
EN  output  1  enable for the downstream tri-state stage
busy  output  1  state != IDLE

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst): it immediately forces state IDLE, rr pointer to "req0 preferred", exec counter 0, operand registers 0, and res_data/res_id/res_zero/res_valid/EN/busy/req*_ready to 0.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If any reqX_valid is high, the arbiter picks a winner and drives that reqX_ready high combinationally. The other ready stays 0.
  - The transfer occurs at that clock edge: operands are latched, the owner id is latched, the counter is loaded with EXEC_CYCLES-1, and the state moves to EXEC.
  - If no valid is high, stay in IDLE.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid: the requester not granted last wins.
  - After reset, req0 wins.
  - The pointer updates only on an actual grant.
- EXEC:
  - Latched operands drive the Subtractor; requester inputs are ignored; both ready outputs are 0.
  - When counter == 0: capture the Subtractor output into res_data, set res_zero, set res_id = owner, and move to DONE. Otherwise decrement the counter.
- DONE:
  - res_valid = 1 and EN = 1; res_data, res_id and res_zero are held stable.
  - When res_ready = 1, the transfer happens at that edge: go to IDLE, and res_valid/EN drop next cycle.
  - res_ready low holds DONE indefinitely.
  - No new request is accepted in DONE; there is one mandatory IDLE cycle between operations.
- Latency: accept edge t produces res_valid from edge t+EXEC_CYCLES. Minimum period is EXEC_CYCLES+2 cycles per operation.
- Arithmetic: 9-bit two's-complement difference a-b. Bit 8 is the borrow out of the MSB stage (1 when a<b unsigned). res_zero ignores the borrow bit.
- res_data keeps its last value after DONE exits and is valid only while res_valid is high.
- A requester dropping valid before its ready pulse causes no transfer. Inputs changing during EXEC do not affect the result.
- rst asserted mid-EXEC or mid-DONE aborts the operation with no result, and the next grant goes to req0.

Decomposition:
- Shared package sub_ctrl_pkg holds:
  - state localparams IDLE=2'b00, EXEC=2'b01, DONE=2'b10
  - ID_REQ0=1'b0, ID_REQ1=1'b1
  - RES_W = WIDTH+1
- Sub-module rr_arbiter_2 (combinational grant plus registered last-grant pointer on clk/rst) keeps the FSM file focused.
- The existing Subtractor module is instantiated unchanged as the datapath.

Test Plan:
- rst=1 at arbitrary time with both valids high -> all outputs 0 immediately; after release, req0_ready=1 on the first cycle.
- req0 a=8'd10 b=8'd3, EXEC_CYCLES=1, res_ready=1 -> res_data=9'h007, res_id=0, res_zero=0, EN=1 exactly one cycle, busy clears after 3 cycles.
- req1 a=8'd3 b=8'd10 -> res_data=9'h1F9 (borrow=1), res_id=1. Then a=b=8'h55 -> res_data=9'h000, res_zero=1.
- Both valids continuously asserted for four operations -> grants alternate req0, req1, req0, req1, with one IDLE cycle between each.
- res_ready held 0 for 5 cycles in DONE -> res_valid, EN and res_data stable; req0_ready and req1_ready stay 0. Asserting res_ready returns the FSM to IDLE.
- EXEC_CYCLES=3, rst pulsed during the second EXEC cycle -> no res_valid; the following simultaneous request grants req0.
